// File: rtl/psum_normalizer_pkg.sv
// Shared types and default sizing for the per-core psum normalizer.
// The remainder width leaves headroom so the shifted remainder never wraps.
package psum_norm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } norm_state_t;

   localparam int COL     = 8;
   localparam int BW_PSUM = 20;
   localparam int QB      = 8;
   localparam int REM_W   = BW_PSUM + 5;

endpackage

// File: rtl/psum_normalizer_if.sv
// Vector-in / vector-out handshake bundle between a core's outputs and its normalizer.
// The master side drives the psum vector and consumes the normalized result.
interface psum_normalizer_if #(
   parameter int col     = psum_norm_pkg::COL,
   parameter int bw_psum = psum_norm_pkg::BW_PSUM,
   parameter int qb      = psum_norm_pkg::QB
);

   logic                     in_valid;
   logic                     in_ready;
   logic [bw_psum*col-1:0]   psum_in;
   logic [bw_psum+3:0]       sum_in;
   logic                     out_valid;
   logic                     out_ready;
   logic [qb*col-1:0]        norm_out;
   logic                     div_zero;

   modport master (
      output in_valid,
      output psum_in,
      output sum_in,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  norm_out,
      input  div_zero
   );

   modport slave (
      input  in_valid,
      input  psum_in,
      input  sum_in,
      input  out_ready,
      output in_ready,
      output out_valid,
      output norm_out,
      output div_zero
   );

endinterface

// File: rtl/psum_normalizer_divider.sv
// Iterative restoring divider: one quotient bit per step cycle after a load.
// o_quot already includes the bit being resolved in the current step cycle.
module psum_divider
   import psum_norm_pkg::*;
#(
   parameter int bw_psum = BW_PSUM,
   parameter int qb      = QB,
   parameter int rem_w   = REM_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_load,
   input  logic               i_step,
   input  logic [bw_psum-1:0] i_a,
   input  logic [bw_psum+3:0] i_sum,
   output logic [qb-1:0]      o_quot,
   output logic               o_zero,
   output logic               o_sat
);

   logic [rem_w-1:0] r_rem;
   logic [rem_w-1:0] r_div;
   logic [qb-1:0]    r_quot;
   logic             r_zero;
   logic             r_sat;

   logic [rem_w-1:0] w_rem2;
   logic [rem_w-1:0] w_rem_nxt;
   logic             w_ge;

   always_comb begin
      w_rem2    = r_rem << 1;
      w_ge      = (w_rem2 >= r_div);
      w_rem_nxt = w_ge ? (w_rem2 - r_div) : w_rem2;
   end

   assign o_quot = (r_quot << 1) | qb'(w_ge);
   assign o_zero = r_zero;
   assign o_sat  = r_sat;

   // Saturated columns keep shifting and may wrap the remainder; their quotient is discarded.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rem  <= '0;
         r_div  <= '0;
         r_quot <= '0;
         r_zero <= 1'b0;
         r_sat  <= 1'b0;
      end else if (i_load) begin
         r_rem  <= rem_w'(i_a);
         r_div  <= rem_w'(i_sum);
         r_quot <= '0;
         r_zero <= (i_sum == '0);
         r_sat  <= (rem_w'(i_a) >= rem_w'(i_sum));
      end else if (i_step) begin
         r_rem  <= w_rem_nxt;
         r_quot <= o_quot;
      end
   end

endmodule

// File: rtl/psum_normalizer.sv
// Per-core normalizer: converts each column psum into |psum|/total as a qb-bit fraction,
// one column at a time through a shared divider, with a fixed latency per vector.
module psum_normalizer
   import psum_norm_pkg::*;
#(
   parameter int col     = COL,
   parameter int bw_psum = BW_PSUM,
   parameter int qb      = QB
) (
   input  logic                clk,
   input  logic                reset,
   psum_normalizer_if.slave    bus
);

   localparam int CW = (col > 1) ? $clog2(col) : 1;
   localparam int SW = $clog2(qb + 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(col - 1);
   localparam logic [SW-1:0] STEP_LAST = SW'(qb);
   localparam logic [qb-1:0] SAT_VAL   = '1;

   norm_state_t               r_state;
   logic [CW-1:0]             r_col_idx;
   logic [SW-1:0]             r_step;
   logic [bw_psum*col-1:0]    r_psum;
   logic [bw_psum+3:0]        r_sum;
   logic [col-1:0][qb-1:0]    r_norm;
   logic                      r_div_zero;
   logic                      r_in_ready;
   logic                      r_out_valid;

   logic [bw_psum-1:0]        w_col;
   logic [bw_psum-1:0]        w_abs;
   logic                      w_load;
   logic                      w_step;
   logic [qb-1:0]             w_quot;
   logic                      w_zero;
   logic                      w_sat;
   logic [qb-1:0]             w_result;

   // The unsigned negate maps the most negative psum onto 2^(bw_psum-1) without widening.
   always_comb begin
      w_col    = r_psum[r_col_idx*bw_psum +: bw_psum];
      w_abs    = w_col[bw_psum-1] ? (~w_col + bw_psum'(1)) : w_col;
      w_load   = (r_state == DIV) && (r_step == '0);
      w_step   = (r_state == DIV) && (r_step != '0);
      w_result = w_quot;
      if (w_zero) begin
         w_result = '0;
      end else if (w_sat) begin
         w_result = SAT_VAL;
      end
   end

   psum_divider #(
      .bw_psum (bw_psum),
      .qb      (qb),
      .rem_w   (bw_psum + 5)
   ) u_divider (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load),
      .i_step  (w_step),
      .i_a     (w_abs),
      .i_sum   (r_sum),
      .o_quot  (w_quot),
      .o_zero  (w_zero),
      .o_sat   (w_sat)
   );

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.norm_out  = r_norm;
   assign bus.div_zero  = r_div_zero;

   // Each column spends one load cycle plus qb step cycles; the last step writes the result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_col_idx   <= '0;
         r_step      <= '0;
         r_psum      <= '0;
         r_sum       <= '0;
         r_norm      <= '0;
         r_div_zero  <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_psum     <= bus.psum_in;
                  r_sum      <= bus.sum_in;
                  r_div_zero <= (bus.sum_in == '0);
                  r_col_idx  <= '0;
                  r_step     <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= DIV;
               end
            end
            DIV: begin
               if (r_step == STEP_LAST) begin
                  r_norm[r_col_idx] <= w_result;
                  r_step            <= '0;
                  if (r_col_idx == COL_LAST) begin
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end else begin
                     r_col_idx <= r_col_idx + CW'(1);
                  end
               end else begin
                  r_step <= r_step + SW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/psum_normalizer.md
# psum_normalizer

Per-core output normalizer sitting directly downstream of the dual-core array. It consumes one core's column partial-sum vector (`out_N`) together with that core's exchanged total (`sum_out_N`). For each column it produces a fixed-point ratio |psum| / total, using one shared iterative restoring divider. Two instances are used, one per core, each driven by its core's outputs.

## Interface
Parameters:
- `col`, 8, number of psum columns
- `bw_psum`, 20, width of one signed column psum
- `qb`, 8, quotient (fraction) bits per normalized output

Ports:
- `clk`  input  1  single clock, rising edge
- `reset`  input  1  asynchronous, active-low reset
- `in_valid`  input  1  psum vector and sum are valid
- `in_ready`  output  1  block can accept a vector
- `psum_in`  input  `bw_psum*col`  signed two's-complement psums; column k at `[bw_psum*(k+1)-1 : bw_psum*k]`
- `sum_in`  input  `bw_psum+4`  unsigned total from `sum_out_N`
- `out_valid`  output  1  normalized vector valid
- `out_ready`  input  1  consumer accepts the vector
- `norm_out`  output  `qb*col`  unsigned normalized values, column k at `[qb*(k+1)-1 : qb*k]`
- `div_zero`  output  1  captured sum was zero; qualified by `out_valid`

## Operation
- State machine has three states: IDLE, DIV, DONE.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE).
- **IDLE:** on `in_valid && in_ready`, the block:
  - registers `psum_in` and `sum_in`;
  - clears `col_idx` and the step counter;
  - moves to DIV.
- **DIV:** each column takes exactly `qb+1` cycles.
  - Step 0 (load): set `a = |psum[col_idx]|` as `bw_psum`-bit unsigned. The most negative value -2^(bw_psum-1) maps to 2^(bw_psum-1).
  - Step 0 also sets per-column flags: `zero = (sum == 0)` and `sat = (a >= sum)`. The remainder is loaded with `a`.
  - Steps 1..qb (restoring division): `r2 = {r,1'b0}`. If `r2 >= sum`, then `r = r2 - sum` and shift in quotient bit 1; otherwise `r = r2` and shift in bit 0.
  - Internal remainder/compare width is `bw_psum+5` bits, so no overflow is possible.
  - After step qb, write the result into `norm_out[col_idx]`:
    - if `zero`: 0;
    - else if `sat`: 2^qb-1;
    - else: the quotient, i.e. floor(a·2^qb / sum).
  - After the write, increment `col_idx`. After column `col-1`, go to DONE.
- Zero-sum and saturated columns still consume the full `qb+1` cycles, so latency is fixed.
- **DONE:** hold `norm_out` and `div_zero` stable until `out_ready`. Then go to IDLE.
- `div_zero` is registered at capture as (`sum_in` == 0).
- `out_ready` in any state other than DONE is ignored. `in_valid` outside IDLE is ignored.

## Timing
- **Reset (async assert, any state):**
  - state = IDLE, `col_idx` = 0, step = 0;
  - `norm_out` = 0, `div_zero` = 0, `out_valid` = 0;
  - `in_ready` = 1 once reset deasserts.
- A vector captured mid-operation is discarded by reset. No partial output is ever presented.
- **Latency:** an accept edge at cycle 0 is followed by DIV for cycles 1..col·(qb+1). `out_valid` rises at cycle col·(qb+1)+1, which is 73 for the defaults.
- **Throughput:** one vector per col·(qb+1)+2 cycles when `out_ready` is held high:
  - the DONE→IDLE transition takes one cycle;
  - `in_ready` is low in DONE, so a same-cycle hand-over is not allowed.
- **Output handshake:** the transfer happens on the edge where `out_valid && out_ready`. `norm_out` must not change while `out_valid` is high.
- `norm_out` columns update only at their own write step. Earlier columns of the current vector may be visible during DIV, but the outputs are unqualified there.

## Structure
- Package `psum_norm_pkg` holds:
  - state enum `norm_state_t` {IDLE, DIV, DONE};
  - default constants `COL`, `BW_PSUM`, `QB`;
  - the derived remainder width `BW_PSUM+5`.
- One sub-module, `psum_divider`: the iterative restoring divider.
  - Inputs: load pulse, unsigned dividend `a`, divisor `sum`.
  - Outputs: `qb`-bit quotient plus `zero`/`sat` flags, valid after `qb` step cycles.
- The top level holds the FSM, capture registers, abs logic, column mux and the output register bank.

## Test plan
- Uniform input, all psums = 16 and sum = 128 → every `norm_out` column = 32, `div_zero` = 0, `out_valid` at cycle 73.
- Sign and saturation: col0 = -64 (0xFFFC0), col1 = 200, col2 = 127, others 0, sum = 128 → col0 = 128, col1 = 255, col2 = 254, others 0.
- Zero sum: any psums with sum = 0 → all columns 0, `div_zero` = 1. Next vector with sum = 1 and psum 0 → `div_zero` = 0.
- Backpressure: hold `out_ready` low for 10 cycles after `out_valid` → `norm_out` stable and `in_ready` = 0 throughout. Release → IDLE next cycle, and the next vector is accepted one cycle later.
- Reset mid-DIV: assert `reset` at cycle 30 of a vector → `out_valid` = 0 and `norm_out` = 0 immediately. After release, `in_ready` = 1, and a fresh vector completes correctly with latency 73.
- Back-to-back: three vectors with `in_valid` held high and `out_ready` = 1 → outputs every 74 cycles, values match the golden floor(|x|·256/sum) model with saturation.
